// File: rtl/quicksort_main.sv
// Sort accelerator: 13-entry signed byte array sorted in place by an iterative quicksort,
// exposed through a 2-channel byte slave port. Define QSORT_DESCEND_EN for descending order.
module quicksort_main #(
  parameter int MEM_var_28860_28869 = 32,
  parameter int MEM_var_29134_28866 = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  input  logic [15:0] M_Rdata_ram,
  input  logic [1:0]  M_DataRdy,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [1:0]  Mout_oe_ram,
  output logic [1:0]  Mout_we_ram,
  output logic [13:0] Mout_addr_ram,
  output logic [15:0] Mout_Wdata_ram,
  output logic [7:0]  Mout_data_ram_size
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_POP, S_PART, S_SWAP, S_PLACE, S_PUSH, S_FIN
  } state_t;

  localparam logic [6:0] ARR_BASE = 7'(MEM_var_28860_28869);
  localparam logic [6:0] ARR_LAST = 7'(MEM_var_28860_28869 + 12);
  localparam logic [6:0] ST_BASE  = 7'(MEM_var_29134_28866 + 16);
  localparam logic [6:0] ST_FLAG  = 7'(MEM_var_29134_28866 + 17);
  localparam logic [7:0] RST_ARR [13] = '{8'h05, 8'hFD, 8'h0C, 8'h00, 8'h07, 8'hF8, 8'h63,
                                          8'h01, 8'h01, 8'h80, 8'h7F, 8'h2A, 8'h06};

  state_t      state_q, state_d;
  logic [7:0]  arr_q [13];
  logic [7:0]  arr_d [13];
  logic [3:0]  stk_lo_q [16];
  logic [3:0]  stk_lo_d [16];
  logic [3:0]  stk_hi_q [16];
  logic [3:0]  stk_hi_d [16];
  logic [4:0]  sp_q, sp_d;
  logic [3:0]  lo_q, lo_d, hi_q, hi_d, i_q, i_d, j_q, j_d;
  logic [7:0]  pivot_q, pivot_d;
  logic [7:0]  swaps_q, swaps_d;
  logic        sorted_q, sorted_d;
  logic        done_q, done_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  rdy_q, rdy_d;

  logic [6:0]  addr_s [2];
  logic [3:0]  off_s [2];
  logic [1:0]  arr_hit_s, st_hit_s;
  logic [3:0]  top_s;
  logic        less_s;
  logic        unused_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign addr_s[0] = S_addr_ram[6:0];
  assign addr_s[1] = S_addr_ram[13:7];
  assign off_s[0]  = 4'(addr_s[0] - ARR_BASE);
  assign off_s[1]  = 4'(addr_s[1] - ARR_BASE);
  assign arr_hit_s[0] = (addr_s[0] >= ARR_BASE) && (addr_s[0] <= ARR_LAST);
  assign arr_hit_s[1] = (addr_s[1] >= ARR_BASE) && (addr_s[1] <= ARR_LAST);
  assign st_hit_s[0]  = (addr_s[0] == ST_BASE) || (addr_s[0] == ST_FLAG);
  assign st_hit_s[1]  = (addr_s[1] == ST_BASE) || (addr_s[1] == ST_FLAG);
  assign top_s = sp_q[3:0] - 4'd1;
  assign unused_s = ^{S_data_ram_size, M_Rdata_ram, M_DataRdy};

`ifdef QSORT_DESCEND_EN
  assign less_s = $signed(arr_q[j_q]) > $signed(pivot_q);
`else
  assign less_s = $signed(arr_q[j_q]) < $signed(pivot_q);
`endif

  // Next-state logic for the sort engine and the slave port.
  always_comb begin
    state_d  = state_q;
    arr_d    = arr_q;
    stk_lo_d = stk_lo_q;
    stk_hi_d = stk_hi_q;
    sp_d     = sp_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    i_d      = i_q;
    j_d      = j_q;
    pivot_d  = pivot_q;
    swaps_d  = swaps_q;
    sorted_d = sorted_q;
    done_d   = 1'b0;
    rdata_d  = 16'h0000;
    rdy_d    = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start_port) begin
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        stk_lo_d[0] = 4'd0;
        stk_hi_d[0] = 4'd12;
        sp_d        = 5'd1;
        swaps_d     = 8'd0;
        state_d     = S_POP;
      end
      S_POP: begin
        if (sp_q == 5'd0) begin
          state_d = S_FIN;
        end else begin
          sp_d = sp_q - 5'd1;
          lo_d = stk_lo_q[top_s];
          hi_d = stk_hi_q[top_s];
          if (stk_lo_q[top_s] >= stk_hi_q[top_s]) begin
            state_d = S_POP;
          end else begin
            pivot_d = arr_q[stk_hi_q[top_s]];
            i_d     = stk_lo_q[top_s];
            j_d     = stk_lo_q[top_s];
            state_d = S_PART;
          end
        end
      end
      S_PART: begin
        if (less_s) begin
          state_d = S_SWAP;
        end else begin
          j_d     = j_q + 4'd1;
          state_d = (j_q + 4'd1 == hi_q) ? S_PLACE : S_PART;
        end
      end
      S_SWAP: begin
        arr_d[i_q] = arr_q[j_q];
        arr_d[j_q] = arr_q[i_q];
        if (i_q != j_q) begin
          swaps_d = sat_inc(swaps_q);
        end else begin
          swaps_d = swaps_q;
        end
        i_d     = i_q + 4'd1;
        j_d     = j_q + 4'd1;
        state_d = (j_q + 4'd1 == hi_q) ? S_PLACE : S_PART;
      end
      S_PLACE: begin
        arr_d[i_q]  = arr_q[hi_q];
        arr_d[hi_q] = arr_q[i_q];
        if (i_q != hi_q) begin
          swaps_d = sat_inc(swaps_q);
        end else begin
          swaps_d = swaps_q;
        end
        state_d = S_PUSH;
      end
      S_PUSH: begin
        // i==lo would underflow i-1; (lo,lo) is an equally empty range
        if (sp_q < 5'd16) begin
          stk_lo_d[sp_q[3:0]] = lo_q;
          stk_hi_d[sp_q[3:0]] = (i_q == lo_q) ? lo_q : i_q - 4'd1;
          if (sp_q < 5'd15) begin
            stk_lo_d[sp_q[3:0] + 4'd1] = i_q + 4'd1;
            stk_hi_d[sp_q[3:0] + 4'd1] = hi_q;
            sp_d = sp_q + 5'd2;
          end else begin
            sp_d = 5'd16;
          end
        end else begin
          sp_d = sp_q;
        end
        state_d = S_POP;
      end
      S_FIN: begin
        sorted_d = 1'b1;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Channel 1 is processed last so it wins a same-byte write collision.
    for (int c = 0; c < 2; c++) begin
      if (S_oe_ram[c]) begin
        if (arr_hit_s[c]) begin
          rdata_d[c*8 +: 8] = arr_q[off_s[c]];
          rdy_d[c]          = 1'b1;
        end else if (st_hit_s[c]) begin
          rdata_d[c*8 +: 8] = (addr_s[c] == ST_BASE) ? swaps_q : {7'd0, sorted_q};
          rdy_d[c]          = 1'b1;
        end else begin
          rdy_d[c] = 1'b0;
        end
      end else if (S_we_ram[c]) begin
        rdy_d[c] = arr_hit_s[c] | st_hit_s[c];
        if (arr_hit_s[c] && (state_q == S_IDLE)) begin
          arr_d[off_s[c]] = S_Wdata_ram[c*8 +: 8];
        end else begin
          rdy_d[c] = arr_hit_s[c] | st_hit_s[c];
        end
      end else begin
        rdy_d[c] = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int k = 0; k < 13; k++) arr_q[k] <= RST_ARR[k];
      for (int k = 0; k < 16; k++) begin
        stk_lo_q[k] <= 4'd0;
        stk_hi_q[k] <= 4'd0;
      end
      sp_q     <= 5'd0;
      lo_q     <= 4'd0;
      hi_q     <= 4'd0;
      i_q      <= 4'd0;
      j_q      <= 4'd0;
      pivot_q  <= 8'd0;
      swaps_q  <= 8'd0;
      sorted_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 16'h0000;
      rdy_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      arr_q    <= arr_d;
      stk_lo_q <= stk_lo_d;
      stk_hi_q <= stk_hi_d;
      sp_q     <= sp_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      i_q      <= i_d;
      j_q      <= j_d;
      pivot_q  <= pivot_d;
      swaps_q  <= swaps_d;
      sorted_q <= sorted_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      rdy_q    <= rdy_d;
    end
  end

  assign done_port          = done_q;
  assign Sout_Rdata_ram     = rdata_q;
  assign Sout_DataRdy       = rdy_q;
  assign Mout_oe_ram        = 2'b00;
  assign Mout_we_ram        = 2'b00;
  assign Mout_addr_ram      = 14'd0;
  assign Mout_Wdata_ram     = 16'h0000;
  assign Mout_data_ram_size = 8'd0;

endmodule

// File: tb/tb_quicksort_main.sv
// Scoreboard bench for quicksort_main: slave accesses push expected acks/data,
// a negedge monitor pops and compares; array contents follow a plain sort model.
module tb_quicksort_main;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_port = 1'b0;
  logic [1:0]  S_oe_ram = 2'b00;
  logic [1:0]  S_we_ram = 2'b00;
  logic [13:0] S_addr_ram = 14'd0;
  logic [15:0] S_Wdata_ram = 16'h0000;
  logic [7:0]  S_data_ram_size = 8'h88;
  logic [15:0] M_Rdata_ram = 16'h0000;
  logic [1:0]  M_DataRdy = 2'b00;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [13:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;

  quicksort_main dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .done_port(done_port), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
    .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size)
  );

  always #5 clock = ~clock;

  localparam logic [7:0] RST_ARR [13] = '{8'h05, 8'hFD, 8'h0C, 8'h00, 8'h07, 8'hF8, 8'h63,
                                          8'h01, 8'h01, 8'h80, 8'h7F, 8'h2A, 8'h06};
  int checks = 0;
  int errors = 0;
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  logic [7:0] mdl [13];
  logic [7:0] mdl_swaps;
  logic [7:0] mdl_sorted;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every acknowledged slave access must match the oldest expectation of its channel.
  always @(negedge clock) begin
    logic [8:0] e;
    if (Sout_DataRdy[0]) begin
      if (exp0.size() == 0) chk("unexpected ack ch0", 1, 0);
      else begin
        e = exp0.pop_front();
        if (e[8]) chk("read data ch0", int'(Sout_Rdata_ram[7:0]), int'(e[7:0]));
      end
    end
    if (Sout_DataRdy[1]) begin
      if (exp1.size() == 0) chk("unexpected ack ch1", 1, 0);
      else begin
        e = exp1.pop_front();
        if (e[8]) chk("read data ch1", int'(Sout_Rdata_ram[15:8]), int'(e[7:0]));
      end
    end
  end

  task automatic push_exp(input int c, input logic [8:0] e);
    if (c == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  task automatic acc(input logic [1:0] oe, input logic [1:0] we, input logic [6:0] a0,
                     input logic [6:0] a1, input logic [7:0] w0, input logic [7:0] w1);
    @(posedge clock); #1;
    S_oe_ram = oe; S_we_ram = we; S_addr_ram = {a1, a0}; S_Wdata_ram = {w1, w0};
    @(posedge clock); #1;
    S_oe_ram = 2'b00; S_we_ram = 2'b00;
  endtask

  task automatic drained();
    @(negedge clock); #1;
    chk("ack latency", exp0.size() + exp1.size(), 0);
  endtask

  task automatic rd(input int c, input logic [6:0] a, input logic [7:0] e, input bit chkd);
    push_exp(c, {chkd, e});
    if (c == 0) acc(2'b01, 2'b00, a, 7'd0, 8'd0, 8'd0);
    else        acc(2'b10, 2'b00, 7'd0, a, 8'd0, 8'd0);
    drained();
  endtask

  task automatic wr(input int c, input logic [6:0] a, input logic [7:0] d, input bit upd);
    push_exp(c, 9'h000);
    if (c == 0) acc(2'b00, 2'b01, a, 7'd0, d, 8'd0);
    else        acc(2'b00, 2'b10, 7'd0, a, 8'd0, d);
    if (upd && a >= 7'd32 && a <= 7'd44) mdl[a - 7'd32] = d;
    drained();
  endtask

  task automatic read_all(input bit swaps_known);
    for (int k = 0; k < 13; k++) rd(k % 2, 7'(32 + k), mdl[k], 1'b1);
    rd(0, 7'd48, mdl_swaps, swaps_known);
    rd(1, 7'd49, mdl_sorted, 1'b1);
  endtask

  task automatic model_sort();
    logic [7:0] t;
    for (int p = 0; p < 12; p++)
      for (int q = 0; q < 12 - p; q++)
`ifdef QSORT_DESCEND_EN
        if ($signed(mdl[q]) < $signed(mdl[q+1])) begin
`else
        if ($signed(mdl[q]) > $signed(mdl[q+1])) begin
`endif
          t = mdl[q]; mdl[q] = mdl[q+1]; mdl[q+1] = t;
        end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1; start_port = 1'b1;
    @(posedge clock); #1; start_port = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clock);
    while (done_port !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("done seen", int'(done_port), 1);
    @(negedge clock);
    chk("done one cycle", int'(done_port), 0);
  endtask

  task automatic run_sort(input bit swaps_known, input logic [7:0] sw);
    pulse_start();
    wait_done();
    model_sort();
    mdl_sorted = 8'd1;
    mdl_swaps  = sw;
    read_all(swaps_known);
  endtask

  task automatic load_random();
    for (int k = 0; k < 13; k++) wr(k % 2, 7'(32 + k), 8'($urandom_range(0, 255)), 1'b1);
  endtask

  initial begin
    int ndone;
    for (int k = 0; k < 13; k++) mdl[k] = RST_ARR[k];
    mdl_swaps = 8'd0;
    mdl_sorted = 8'd0;
    #1 reset = 1'b1;
    #2;
    chk("reset done", int'(done_port), 0);
    chk("reset rdata", int'(Sout_Rdata_ram), 0);
    chk("reset rdy", int'(Sout_DataRdy), 0);
    chk("mout quiet", int'({Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    read_all(1'b1);

    // Reset contents sorted; same-cycle dual read of the smallest and largest entries.
    run_sort(1'b0, 8'd0);
    exp0.push_back({1'b1, mdl[0]});
    exp1.push_back({1'b1, mdl[12]});
    acc(2'b11, 2'b00, 7'd32, 7'd44, 8'd0, 8'd0);
    chk("dual read data", int'(Sout_Rdata_ram), int'(16'h7F80));
    chk("dual read rdy", int'(Sout_DataRdy), 3);
    drained();

    // Already-sorted input: every exchange is with itself.
    for (int k = 0; k < 13; k++) wr(k % 2, 7'(32 + k), 8'(k), 1'b1);
    run_sort(1'b1, 8'd0);

    // All-equal input: nothing is less than the pivot, so each of the 12 partitions
    // (ranges k..12) ends with a real PLACE exchange of i=lo against hi.
    for (int k = 0; k < 13; k++) wr(k % 2, 7'(32 + k), 8'd7, 1'b1);
    run_sort(1'b1, 8'd12);

    // Status writes are acknowledged but ignored; same-byte write collision goes to channel 1.
    wr(0, 7'd48, 8'hFF, 1'b0);
    rd(1, 7'd48, mdl_swaps, 1'b1);
    exp0.push_back(9'h000);
    exp1.push_back(9'h000);
    acc(2'b00, 2'b11, 7'd35, 7'd35, 8'hAA, 8'hBB);
    mdl[3] = 8'hBB;
    drained();
    rd(0, 7'd35, mdl[3], 1'b1);

    for (int r = 0; r < 4; r++) begin
      load_random();
      run_sort(1'b0, 8'd0);
    end

    // Writes during a sort are acknowledged but dropped; misses give no ack and zero data.
    load_random();
    pulse_start();
    repeat (2) @(posedge clock);
    wr(0, 7'd33, 8'h55, 1'b0);
    acc(2'b01, 2'b00, 7'd70, 7'd0, 8'd0, 8'd0);
    chk("miss rdy", int'(Sout_DataRdy[0]), 0);
    chk("miss data", int'(Sout_Rdata_ram[7:0]), 0);
    wait_done();
    model_sort();
    mdl_sorted = 8'd1;
    read_all(1'b0);

    // Reset in the middle of partitioning restores the power-up state at once.
    load_random();
    pulse_start();
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort done", int'(done_port), 0);
    chk("abort rdata", int'(Sout_Rdata_ram), 0);
    chk("abort rdy", int'(Sout_DataRdy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 13; k++) mdl[k] = RST_ARR[k];
    mdl_swaps = 8'd0;
    mdl_sorted = 8'd0;
    ndone = 0;
    repeat (60) begin
      @(negedge clock);
      if (done_port) ndone++;
    end
    chk("no done after abort", ndone, 0);
    read_all(1'b1);
    wr(1, 7'd32, 8'h11, 1'b1);
    rd(0, 7'd32, mdl[0], 1'b1);
    chk("mout quiet end", int'({Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
